// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - opcode/state enums and the single-cycle ALU helper for alu_pipe
package alu_pipe_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_LSL, OP_LSR, OP_ROL, OP_ROR,
    OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_XNOR, OP_GT, OP_EQ
  } op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  // Operands arrive zero-extended to MAX_W; w is the live width. Returns {carry, result}.
  function automatic logic [MAX_W:0] alu_simple(input op_e op, input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b, input int unsigned w);
    logic [MAX_W-1:0] mask, r;
    logic [MAX_W:0]   sum;
    logic             c;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    sum  = {1'b0, a} + {1'b0, b};
    r    = '0;
    c    = 1'b0;
    case (op)
      OP_ADD:  begin r = sum[MAX_W-1:0]; c = sum[7'(w)]; end
      OP_SUB:  begin r = a - b; c = (a < b); end
      OP_DIV:  r = (b == '0) ? mask : '0;
      OP_LSL:  begin r = a << 1; c = a[6'(w - 1)]; end
      OP_LSR:  begin r = a >> 1; c = a[0]; end
      OP_ROL:  r = (a << 1) | MAX_W'(a[6'(w - 1)]);
      OP_ROR:  r = (a >> 1) | (MAX_W'(a[0]) << (w - 1));
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      OP_XNOR: r = ~(a ^ b);
      OP_GT:   r = MAX_W'(a > b);
      OP_EQ:   r = MAX_W'(a == b);
      default: r = '0;
    endcase
    return {c, r & mask};
  endfunction

endpackage

// File: rtl/alu_pipe_muldiv.sv
// rtl/alu_pipe_muldiv.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
// done flags the final iteration; result/overflow show that iteration's outcome combinationally.
module alu_pipe_muldiv
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             r_run, r_mul;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dsor, r_rem, r_q;
  logic [2*WIDTH:0] r_p;

  logic [WIDTH:0]   w_sum, w_shift;
  logic [WIDTH+1:0] w_trial;
  logic [2*WIDTH:0] w_p_next;
  logic [WIDTH-1:0] w_q_next, w_rem_next;
  logic             w_unused;

  assign w_sum    = r_p[2*WIDTH:WIDTH] + (r_p[0] ? {1'b0, r_dsor} : '0);
  assign w_p_next = {w_sum, r_p[WIDTH-1:0]} >> 1;

  // Trial subtract carries an extra sign bit: the shifted remainder can exceed WIDTH bits.
  assign w_shift    = {r_rem, r_q[WIDTH-1]};
  assign w_trial    = {1'b0, w_shift} - {2'b00, r_dsor};
  assign w_q_next   = {r_q[WIDTH-2:0], ~w_trial[WIDTH+1]};
  assign w_rem_next = w_trial[WIDTH+1] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_unused   = w_trial[WIDTH] ^ w_shift[WIDTH] ^ w_p_next[2*WIDTH];

  assign done     = r_run && (r_cnt == LAST);
  assign result   = r_mul ? w_p_next[WIDTH-1:0] : w_q_next;
  assign overflow = r_mul && (|w_p_next[2*WIDTH-1:WIDTH]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run  <= 1'b0;
      r_mul  <= 1'b0;
      r_cnt  <= '0;
      r_dsor <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_p    <= '0;
    end else if (start) begin
      r_run  <= 1'b1;
      r_mul  <= (op == OP_MUL);
      r_cnt  <= '0;
      r_dsor <= (op == OP_MUL) ? a : b;
      r_rem  <= '0;
      r_q    <= a;
      r_p    <= {(WIDTH+1)'(0), b};
    end else if (r_run) begin
      r_cnt <= r_cnt + CW'(1);
      if (done) r_run <= 1'b0;
      if (r_mul) begin
        r_p <= w_p_next;
      end else begin
        r_q   <= w_q_next;
        r_rem <= w_rem_next;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - valid/ready ALU top (WIDTH 4..63)
// ALU_PIPE_MULDIV_EN enables iterative MUL/DIV; otherwise ops 2/3 return 0 in one cycle.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             div_by_zero
);

  state_e           r_state, w_next;
  logic             r_live, r_carry, r_dbz;
  logic [WIDTH-1:0] r_result;

  op_e              w_op;
  logic             w_accept, w_is_iter, w_md_done, w_md_ovf;
  logic [WIDTH-1:0] w_md_result;
  logic [MAX_W:0]   w_simple;
  logic             w_unused_hi;

  assign w_op        = op_e'(op);
  assign w_simple    = alu_simple(w_op, MAX_W'(a), MAX_W'(b), WIDTH);
  assign w_unused_hi = |w_simple[MAX_W-1:WIDTH];

  // r_live holds in_ready low until the first edge after reset release.
  assign in_ready    = r_live && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
  assign w_accept    = in_valid && in_ready;
  assign out_valid   = (r_state == ST_DONE);
  assign result      = r_result;
  assign carry_out   = r_carry;
  assign zero        = out_valid && (r_result == '0);
  assign div_by_zero = r_dbz;

`ifdef ALU_PIPE_MULDIV_EN
  assign w_is_iter = (w_op == OP_MUL) || ((w_op == OP_DIV) && (b != '0));

  alu_pipe_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_accept && w_is_iter),
    .op       (w_op),
    .a        (a),
    .b        (b),
    .done     (w_md_done),
    .result   (w_md_result),
    .overflow (w_md_ovf)
  );
`else
  assign w_is_iter   = 1'b0;
  assign w_md_done   = 1'b0;
  assign w_md_result = '0;
  assign w_md_ovf    = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept)                                 w_next = w_is_iter ? ST_BUSY : ST_DONE;
        else if ((r_state == ST_DONE) && out_ready)   w_next = ST_IDLE;
      end
      ST_BUSY: if (w_md_done) w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_live   <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
      if (w_accept && !w_is_iter) begin
        r_result <= w_simple[WIDTH-1:0];
        r_carry  <= w_simple[MAX_W];
        r_dbz    <= (w_op == OP_DIV) && (b == '0);
      end else if ((r_state == ST_BUSY) && w_md_done) begin
        r_result <= w_md_result;
        r_carry  <= w_md_ovf;
        r_dbz    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe (WIDTH=8), both ALU_PIPE_MULDIV_EN builds
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, result;
  logic [3:0] op;
  logic       carry_out, zero, div_by_zero;

  int   checks = 0;
  int   errors = 0;
  int   lat;
  logic rdy_seen, stable, seen;

`ifdef ALU_PIPE_MULDIV_EN
  localparam logic [7:0] MUL_RES = 8'h6E;
  localparam logic       MUL_C   = 1'b1;
  localparam logic [7:0] DIV_RES = 8'h01;
  localparam int         ITER_LAT = 9;
`else
  localparam logic [7:0] MUL_RES = 8'h00;
  localparam logic       MUL_C   = 1'b0;
  localparam logic [7:0] DIV_RES = 8'h00;
  localparam int         ITER_LAT = 1;
`endif

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .zero(zero), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Latency counted in cycles including the accept edge; bounded so a stuck DUT still ends.
  task automatic wait_valid(output int n, output logic rdy);
    n = 1;
    rdy = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) rdy = 1'b1;
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_zero", zero, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("in_ready_after_rst", in_ready, 1);

    issue(4'd0, 8'h6A, 8'h3B);
    chk("add_valid_1cyc", out_valid, 1);
    chk("add_result", result, 8'hA5);
    chk("add_carry", carry_out, 0);
    chk("add_zero", zero, 0);

    issue(4'd0, 8'hFF, 8'h01);
    chk("add_wrap_result", result, 8'h00);
    chk("add_wrap_carry", carry_out, 1);
    chk("add_wrap_zero", zero, 1);

    issue(4'd1, 8'h3B, 8'h6A);
    chk("sub_result", result, 8'hD1);
    chk("sub_borrow", carry_out, 1);

    issue(4'd2, 8'h6A, 8'h3B);
    wait_valid(lat, rdy_seen);
    chk("mul_latency", lat, ITER_LAT);
    chk("mul_in_ready_busy", rdy_seen, 0);
    chk("mul_result", result, MUL_RES);
    chk("mul_carry", carry_out, MUL_C);
    chk("mul_zero", zero, (MUL_RES == 8'h00));

    issue(4'd3, 8'h6A, 8'h3B);
    wait_valid(lat, rdy_seen);
    chk("div_latency", lat, ITER_LAT);
    chk("div_result", result, DIV_RES);
    chk("div_carry", carry_out, 0);
    chk("div_dbz", div_by_zero, 0);

    issue(4'd3, 8'h6A, 8'h00);
    chk("div0_valid_1cyc", out_valid, 1);
    chk("div0_result", result, 8'hFF);
    chk("div0_dbz", div_by_zero, 1);
    chk("div0_carry", carry_out, 0);

    op = 4'd6; a = 8'h6A; b = 8'h00; in_valid = 1'b1;
    tick();
    chk("rol_valid", out_valid, 1);
    chk("rol_result", result, 8'hD4);
    chk("rol_carry", carry_out, 0);
    chk("rol_dbz_cleared", div_by_zero, 0);
    op = 4'd5;
    tick();
    in_valid = 1'b0;
    chk("lsr_b2b_valid", out_valid, 1);
    chk("lsr_result", result, 8'h35);
    chk("lsr_carry", carry_out, 0);

    issue(4'd4, 8'hA5, 8'h00);
    chk("lsl_result", result, 8'h4A);
    chk("lsl_carry", carry_out, 1);
    tick();

    out_ready = 1'b0;
    issue(4'd10, 8'h6A, 8'h3B);
    chk("xor_result", result, 8'h51);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 4'($urandom); in_valid = 1'b1;
      if (result !== 8'h51 || in_ready !== 1'b0 || out_valid !== 1'b1 || carry_out !== 1'b0) stable = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    chk("backpressure_stable", stable, 1);
    chk("backpressure_result", result, 8'h51);
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    tick();
    chk("released_out_valid", out_valid, 0);

    issue(4'd2, 8'h6A, 8'h3B);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_carry", carry_out, 0);
    chk("midrst_in_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", seen, 0);

    issue(4'd15, 8'h3B, 8'h3B);
    chk("eq_valid", out_valid, 1);
    chk("eq_result", result, 8'h01);
    chk("eq_carry", carry_out, 0);

    issue(4'd14, 8'h3B, 8'h6A);
    chk("gt_result", result, 8'h00);
    chk("gt_zero", zero, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
